fifo_master_ctrl: RTL
=====================

Name: fifo_master_ctrl

Overview:
- Parametrised, register-mapped FIFO master; next generation of the single-FIFO bus front end.
- Adds configurable data width and depth, and sticky write-1-to-clear error flags.
- Adds programmable almost-full/almost-empty thresholds, a level readout, flush, a maskable interrupt, and registered read data with an explicit response/error handshake.
- Sits between the block-level register bus (enable/addr/write/read) and local FIFO storage.

Parameters:
DATA_W, 8, width of wdata/rdata and FIFO words (>= 8)
DEPTH, 16, FIFO entries; power of two, >= 4
ADDR_W, 3, register address width
LVL_W, $clog2(DEPTH)+1, width of level count and thresholds (derived, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  bus access qualifier
addr  in  ADDR_W  register address
write  in  1  write strobe (qualified by enable)
read  in  1  read strobe (qualified by enable)
wdata  in  DATA_W  write data
rdata  out  DATA_W  registered read data, valid when resp=1
resp  out  1  one-cycle access-complete pulse
resp_err  out  1  error qualifier, valid with resp
irq  out  1  level interrupt, |(STAT[5:0] & IRQ_MASK)

Behaviour:
- Reset (rst_n=0, async): rdata=0, resp=0, resp_err=0, irq=0.
  - Pointers and level = 0; sticky flags = 0.
  - CTRL.en=1; AF_THR=DEPTH-1; AE_THR=1; IRQ_MASK=0.
- Access: enable=1 with exactly one of write/read.
  - resp pulses in the following cycle; read data appears on rdata in that same cycle (latency 1).
  - enable with both write and read: no state change; resp=1, resp_err=1, rdata=0.
  - enable with neither: no response.
- Register map (unused upper bits read 0, ignored on write):
  - 0 DATA: write pushes wdata; read pops and returns the head word.
  - 1 STAT: [0] empty, [1] full, [2] overflow (sticky), [3] underflow (sticky), [4] almost_full (level >= AF_THR), [5] almost_empty (level <= AE_THR).
    - Writing 1 to bit 2 or 3 clears that flag; other bits are read-only.
  - 2 LEVEL: current entry count, 0..DEPTH.
  - 3 CTRL: [0] en, [1] flush (write-only, self-clearing).
    - Flush resets pointers and level in the same cycle; sticky flags are kept.
  - 4 AF_THR, 5 AE_THR: LVL_W-bit thresholds.
  - 6 IRQ_MASK: [5:0].
  - 7 unmapped: resp_err=1, rdata=0.
- Push when full: data dropped, overflow set, resp_err=1.
- Pop when empty: rdata=0, underflow set, resp_err=1.
- CTRL.en=0: DATA accesses have no effect and return resp_err=1; sticky flags are not set.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Level is a separate up/down counter; it is never simultaneously incremented and decremented, because there is a single access port.
- Storage write is synchronous. The head word is read combinationally from the core and captured into rdata on the pop edge.
- Status flags derive combinationally from level and thresholds. irq is registered, so it lags a flag change by one cycle.
- Thresholds above DEPTH are legal: almost_full then never asserts.
- rst_n asserted mid-access: the pending resp is cancelled and all state returns to reset values immediately.

Decomposition:
- Package fifo_master_pkg holds:
  - Register address localparams (REG_DATA..REG_IRQ_MASK).
  - STAT bit-index constants.
  - CTRL bit-index constants.
- One sub-module, sync_fifo_core (DATA_W, DEPTH): storage array, wr/rd pointers, level counter, flush, full/empty. It knows nothing about bus semantics.
- fifo_master_ctrl owns decode, sticky flags, thresholds, rdata/resp registers and irq.

Test Plan:
- Reset, then read STAT, LEVEL, AF_THR: STAT=0x21 (empty, almost_empty), LEVEL=0, AF_THR=15; irq=0.
- Push 0xA1,0xB2,0xC3, then pop three times: rdata=0xA1,0xB2,0xC3 one cycle after each read with resp=1, resp_err=0; LEVEL then reads 0.
- Push 17 words into DEPTH=16: 17th gives resp_err=1, STAT[2]=1, LEVEL=16. Then write STAT=0x04: STAT[2]=0, STAT[1] stays 1.
- Pop when empty: rdata=0, resp_err=1, STAT[3]=1. With IRQ_MASK=0x08, irq=1 one cycle later; W1C clears it.
- Set AF_THR=4, push 4 words: STAT[4]=1. Write CTRL=0x02 (flush): LEVEL=0, STAT[0]=1, STAT[4]=0.
- Wrap-around: push/pop interleaved for 40 words (DEPTH=16) keeps FIFO order. Unmapped addr 7 and write+read together both give resp_err=1 with no state change.

Source files
------------

// File: rtl/fifo_master_pkg.sv
// Shared register map and bit positions for the FIFO master register block.
package fifo_master_pkg;

  localparam int REG_DATA     = 0;
  localparam int REG_STAT     = 1;
  localparam int REG_LEVEL    = 2;
  localparam int REG_CTRL     = 3;
  localparam int REG_AF_THR   = 4;
  localparam int REG_AE_THR   = 5;
  localparam int REG_IRQ_MASK = 6;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_UDF   = 3;
  localparam int STAT_AF    = 4;
  localparam int STAT_AE    = 5;
  localparam int STAT_W     = 6;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

endpackage

// File: rtl/fifo_master_ctrl_core.sv
// Bus-agnostic synchronous FIFO: storage, wrapping pointers, level counter, flush.
module sync_fifo_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      level_d  = level_q + LW'(1);
    end else if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      level_d  = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage has no reset; contents are never observable before being written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/fifo_master_ctrl.sv
// Register-mapped FIFO master: decode, sticky flags, thresholds, registered response and irq.
module fifo_master_ctrl
  import fifo_master_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              resp,
  output logic              resp_err,
  output logic              irq
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_q, resp_d;
  logic              resp_err_q, resp_err_d;
  logic              irq_q, irq_d;
  logic              en_q, en_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [LVL_W-1:0]  af_thr_q, af_thr_d;
  logic [LVL_W-1:0]  ae_thr_q, ae_thr_d;
  logic [STAT_W-1:0] irq_mask_q, irq_mask_d;

  logic              push, pop, flush;
  logic [DATA_W-1:0] head;
  logic [LVL_W-1:0]  level;
  logic              full, empty;
  logic [STAT_W-1:0] stat;

  sync_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    stat             = '0;
    stat[STAT_EMPTY] = empty;
    stat[STAT_FULL]  = full;
    stat[STAT_OVF]   = ovf_q;
    stat[STAT_UDF]   = udf_q;
    stat[STAT_AF]    = (level >= af_thr_q);
    stat[STAT_AE]    = (level <= ae_thr_q);
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    rdata_d    = '0;
    resp_d     = 1'b0;
    resp_err_d = 1'b0;
    en_d       = en_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    af_thr_d   = af_thr_q;
    ae_thr_d   = ae_thr_q;
    irq_mask_d = irq_mask_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;

    if (enable && write && read) begin
      resp_d     = 1'b1;
      resp_err_d = 1'b1;
    end else if (enable && (write || read)) begin
      resp_d = 1'b1;
      case (addr)
        ADDR_W'(REG_DATA): begin
          if (!en_q) begin
            resp_err_d = 1'b1;
          end else if (write) begin
            if (full) begin
              resp_err_d = 1'b1;
              ovf_d      = 1'b1;
            end else begin
              push = 1'b1;
            end
          end else begin
            if (empty) begin
              resp_err_d = 1'b1;
              udf_d      = 1'b1;
            end else begin
              pop     = 1'b1;
              rdata_d = head;
            end
          end
        end
        ADDR_W'(REG_STAT): begin
          if (write) begin
            if (wdata[STAT_OVF]) ovf_d = 1'b0;
            if (wdata[STAT_UDF]) udf_d = 1'b0;
          end else begin
            rdata_d = DATA_W'(stat);
          end
        end
        ADDR_W'(REG_LEVEL): begin
          if (read) rdata_d = DATA_W'(level);
        end
        ADDR_W'(REG_CTRL): begin
          if (write) begin
            en_d  = wdata[CTRL_EN];
            flush = wdata[CTRL_FLUSH];
          end else begin
            rdata_d = DATA_W'(en_q);
          end
        end
        ADDR_W'(REG_AF_THR): begin
          if (write) af_thr_d = wdata[LVL_W-1:0];
          else       rdata_d  = DATA_W'(af_thr_q);
        end
        ADDR_W'(REG_AE_THR): begin
          if (write) ae_thr_d = wdata[LVL_W-1:0];
          else       rdata_d  = DATA_W'(ae_thr_q);
        end
        ADDR_W'(REG_IRQ_MASK): begin
          if (write) irq_mask_d = wdata[STAT_W-1:0];
          else       rdata_d    = DATA_W'(irq_mask_q);
        end
        default: resp_err_d = 1'b1;
      endcase
    end

    // Registered from current flags, so irq trails any flag or mask change by one cycle.
    irq_d = |(stat & irq_mask_q);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      resp_q     <= 1'b0;
      resp_err_q <= 1'b0;
      irq_q      <= 1'b0;
      en_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      af_thr_q   <= LVL_W'(DEPTH - 1);
      ae_thr_q   <= LVL_W'(1);
      irq_mask_q <= '0;
    end else begin
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      resp_err_q <= resp_err_d;
      irq_q      <= irq_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      af_thr_q   <= af_thr_d;
      ae_thr_q   <= ae_thr_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  assign rdata    = rdata_q;
  assign resp     = resp_q;
  assign resp_err = resp_err_q;
  assign irq      = irq_q;

endmodule
